bubble_sort_ctrl: RTL and testbench
===================================

Name: bubble_sort_ctrl

Overview:
- Sequencer that sorts N unsigned DATA_WIDTH-bit words in place, ascending, inside the team's single-port array RAM.
- Sits directly upstream of the RAM and owns its addr, data_in and we inputs.
- Consumes the RAM's data_out. That output is registered with 1-cycle latency and is read-first, meaning it returns the old contents when the same address is written in that cycle.
- Algorithm is bubble sort with early exit on a pass that makes no swap; a start/busy/done handshake faces the host.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- ADDR_WIDTH, 4, RAM address width; must match the RAM.
- N, 16, number of elements sorted, at addresses 0..N-1; legal range 2..2**ADDR_WIDTH.
- CNT_WIDTH, 16, swap counter width; must hold N*(N-1)/2.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sort; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the sort completes.
- swap_count  output  CNT_WIDTH  swaps made in the last or current sort.
- ram_addr  output  ADDR_WIDTH  connects to the RAM addr.
- ram_we  output  1  connects to the RAM we.
- ram_wdata  output  DATA_WIDTH  connects to the RAM data_in.
- ram_rdata  input  DATA_WIDTH  connects to the RAM data_out; valid 1 cycle after the address is presented.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, swap_count=0, ram_addr=0, ram_we=0, ram_wdata=0.
- Internal registers: j (compare index), last_j (upper index limit for the current pass), a_reg, b_reg, swapped flag.
- IDLE: when start=1, load j=0 and last_j=N-2, clear swapped and swap_count, then go to RD_A. start is ignored in every other state.
- RD_A: ram_addr=j, ram_we=0. Next state RD_B.
- RD_B: ram_addr=j+1. Capture a_reg<=ram_rdata, which is mem[j]. Next state CMP.
- CMP: ram_rdata is mem[j+1].
  - If a_reg > ram_rdata (unsigned): b_reg<=ram_rdata, swapped<=1, swap_count++, go to WR_A.
  - Otherwise, with no swap, take the ADVANCE decision.
  - Equal values never swap, so the sort is stable.
- WR_A: ram_addr=j, ram_we=1, ram_wdata=b_reg. Next state WR_B.
- WR_B: ram_addr=j+1, ram_we=1, ram_wdata=a_reg. Then take the ADVANCE decision.
- ADVANCE, evaluated in the leaving cycle of CMP (no-swap case) or of WR_B:
  - If j<last_j: j++ and go to RD_A.
  - Otherwise, if last_j==0 or no swap happened in this pass (swapped flag including this cycle's swap is 0): go to DONE.
  - Otherwise: last_j--, j=0, swapped=0, go to RD_A.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. swap_count holds until the next accepted start.
- ram_we is high only in WR_A and WR_B. ram_rdata is ignored in those states.
- Cost per comparison: 3 cycles without a swap, 5 with a swap.
- Latency example: input already sorted with N=16 gives 15x3=45 busy cycles, then the DONE cycle. done is high in the 46th cycle after the cycle in which start was sampled.
- Reset mid-sort: immediate return to IDLE with all outputs at reset values. RAM contents are left partially sorted (still a permutation only if the reset lands outside WR_A..WR_B); there is no resume.
- The host must not access the RAM while busy=1.

Decomposition:
- Package sort_pkg holds the sort_state_t enum (IDLE, RD_A, RD_B, CMP, WR_A, WR_B, DONE) and the default DATA_WIDTH/ADDR_WIDTH constants, shared with the RAM and the test bench.
- No sub-module. The compare is a single unsigned greater-than inside the FSM.

Test Plan:
- Setup: the bench instantiates the RAM, preloads it through a backdoor, and pulses start for one cycle.
- Sorted input 0..15 -> swap_count=0, a single pass, done in cycle 46, RAM unchanged.
- Reversed input 15..0 -> swap_count=120, RAM reads 0..15, done pulse is exactly 1 cycle wide, busy falls the following cycle.
- All-equal input 8'h5A x16 -> swap_count=0, no cycle with ram_we=1.
- Mixed input {200,3,3,255,0,...} with N=2 override on the first two values only: {200,3} -> {3,200}, swap_count=1, addresses >=2 untouched.
- start held high throughout and pulsed again mid-sort -> exactly one done per accepted start; the second sort begins only after IDLE.
- rst_n low in the middle of a WR_A cycle -> busy, done and ram_we go to 0 immediately (asynchronously). A subsequent start sorts the array correctly.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and default geometry for the in-place bubble sort sequencer
// and the single-port array RAM it drives.
package sort_pkg;
  localparam int SORT_DATA_WIDTH = 8;
  localparam int SORT_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    DONE
  } sort_state_t;
endpackage

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer driving a single-port RAM with read-first,
// 1-cycle registered read data; sorts mem[0..N-1] ascending, early exit.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = SORT_DATA_WIDTH,
  parameter int ADDR_WIDTH = SORT_ADDR_WIDTH,
  parameter int N          = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam logic [ADDR_WIDTH-1:0] LAST_J0 = ADDR_WIDTH'(N - 2);

  sort_state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] j, last_j, j_p1;
  logic [DATA_WIDTH-1:0] a_reg, b_reg;
  logic                  swapped;
  logic                  gt, adv, adv_more, adv_done;
  sort_state_t           adv_state;

  assign j_p1     = j + ADDR_WIDTH'(1);
  assign gt       = a_reg > ram_rdata;
  assign adv      = (state == CMP && !gt) || (state == WR_B);
  assign adv_more = j < last_j;
  // In WR_B swapped is already set, so the register alone covers this cycle.
  assign adv_done = (last_j == '0) || !swapped;
  assign adv_state = (adv_more || !adv_done) ? RD_A : DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = CMP;
      CMP:     state_nxt = gt ? WR_A : adv_state;
      WR_A:    state_nxt = WR_B;
      WR_B:    state_nxt = adv_state;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state)
      RD_A: ram_addr = j;
      RD_B: ram_addr = j_p1;
      WR_A: begin ram_addr = j;    ram_we = 1'b1; ram_wdata = b_reg; end
      WR_B: begin ram_addr = j_p1; ram_we = 1'b1; ram_wdata = a_reg; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j          <= '0;
      last_j     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        j          <= '0;
        last_j     <= LAST_J0;
        swapped    <= 1'b0;
        swap_count <= '0;
      end
      if (state == RD_B) a_reg <= ram_rdata;
      if (state == CMP && gt) begin
        b_reg      <= ram_rdata;
        swapped    <= 1'b1;
        swap_count <= swap_count + CNT_WIDTH'(1);
      end
      if (adv) begin
        if (adv_more) begin
          j <= j_p1;
        end else if (!adv_done) begin
          // Largest remaining value has bubbled to last_j+1; shrink the pass.
          last_j  <= last_j - ADDR_WIDTH'(1);
          j       <= '0;
          swapped <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench: two sequencers (N=16 and N=2) each on a behavioural
// read-first RAM, checking sort results, swap counts, latency and reset.
module tb_bubble_sort_ctrl;
  import sort_pkg::*;
  localparam int DW = SORT_DATA_WIDTH;
  localparam int AW = SORT_ADDR_WIDTH;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, start2 = 1'b0;
  logic          busy, done, ram_we, busy2, done2, ram_we2;
  logic [CW-1:0] swap_count, swap_count2;
  logic [AW-1:0] ram_addr, ram_addr2;
  logic [DW-1:0] ram_wdata, ram_rdata, ram_wdata2, ram_rdata2;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mem2 [16];

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bubble_sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(16), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .swap_count(swap_count), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  bubble_sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N(2), .CNT_WIDTH(CW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .swap_count(swap_count2), .ram_addr(ram_addr2), .ram_we(ram_we2),
    .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2));

  // read-first single-port RAMs
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
    ram_rdata2 <= mem2[ram_addr2];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // 0: ascending 0..15, 1: descending 15..0, 2: all 8'h5A
  task automatic load(input int kind);
    for (int i = 0; i < 16; i++)
      case (kind)
        0:       mem[i] <= 8'(i);
        1:       mem[i] <= 8'(15 - i);
        default: mem[i] <= 8'h5A;
      endcase
  endtask

  task automatic run(output int cyc, output int we_cnt);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; we_cnt = 0;
    while (!done && cyc < 2000) begin
      if (ram_we) we_cnt++;
      @(negedge clk); cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, we_cnt, nd, d1, d2, idle, c;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_swap", swap_count, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    rst_n = 1'b1;

    // already sorted: single pass, 15 x 3 cycles, done in cycle 46
    load(0);
    run(cyc, we_cnt);
    chk("sorted_cyc", cyc, 46);
    chk("sorted_swap", swap_count, 0);
    chk("sorted_we", we_cnt, 0);
    for (int i = 0; i < 16; i++) chk("sorted_mem", mem[i], i);

    // reversed: 120 swaps x 5 cycles, done in cycle 601
    load(1);
    run(cyc, we_cnt);
    chk("rev_cyc", cyc, 601);
    chk("rev_swap", swap_count, 120);
    chk("rev_we", we_cnt, 240);
    for (int i = 0; i < 16; i++) chk("rev_mem", mem[i], i);

    // all equal: never swaps
    load(2);
    run(cyc, we_cnt);
    chk("eq_cyc", cyc, 46);
    chk("eq_swap", swap_count, 0);
    chk("eq_we", we_cnt, 0);

    // N=2 instance: {200,3} -> {3,200}, rest untouched
    mem2[0] <= 8'd200; mem2[1] <= 8'd3; mem2[2] <= 8'd3; mem2[3] <= 8'd255; mem2[4] <= 8'd0;
    for (int i = 5; i < 16; i++) mem2[i] <= 8'd7;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("n2_cyc", cyc, 6);
    chk("n2_swap", swap_count2, 1);
    chk("n2_m0", mem2[0], 3);
    chk("n2_m1", mem2[1], 200);
    chk("n2_m2", mem2[2], 3);
    chk("n2_m3", mem2[3], 255);
    chk("n2_m4", mem2[4], 0);
    chk("n2_m5", mem2[5], 7);
    @(negedge clk);
    chk("n2_busy_after", busy2, 0);

    // start held high: back-to-back sorts, done at 46 and 93
    load(0);
    @(negedge clk); start = 1'b1;
    nd = 0; d1 = 0; d2 = 0; idle = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin nd++; if (nd == 1) d1 = i; else d2 = i; end
      if (!busy) idle++;
    end
    start = 1'b0;
    chk("hold_ndone", nd, 2);
    chk("hold_d1", d1, 46);
    chk("hold_d2", d2, 93);
    chk("hold_idle", idle, 2);
    c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    chk("hold_drain", busy, 0);

    // second start pulse mid-sort is ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0; d1 = 0;
    for (int i = 10; i < 100; i++) begin
      if (done) begin nd++; d1 = i; end
      @(negedge clk);
    end
    chk("mid_ndone", nd, 1);
    chk("mid_dcyc", d1, 46);
    chk("mid_busy", busy, 0);

    // async reset in WR_A of the first compare (15 vs 14)
    load(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("wra_we", ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_we", ram_we, 0);
    chk("arst_swap", swap_count, 0);
    chk("arst_addr", ram_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    chk("arst_m0", mem[0], 15);
    chk("arst_m1", mem[1], 14);
    run(cyc, we_cnt);
    chk("resort_swap", swap_count, 120);
    for (int i = 0; i < 16; i++) chk("resort_mem", mem[i], i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
